// File: rtl/sr_pkg.sv
// Shared types for the SR bank loader: FSM states and per-bit excitation actions.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Action encoding is {S,R}; ILLEGAL exists only so checkers can name it.
    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        CLR     = 2'b01,
        SET     = 2'b10,
        ILLEGAL = 2'b11
    } act_e;

    function automatic act_e excite_bit(input logic tgt, input logic q);
        if (tgt && !q) begin
            return SET;
        end else if (!tgt && q) begin
            return CLR;
        end
        return HOLD;
    endfunction

endpackage

// File: rtl/sr_excite.sv
// Word-wide SR excitation: per bit, set / clear / hold to move q towards tgt.
// Only SET or CLR is ever produced per bit, so s_o & r_o is always zero.
module sr_excite
    import sr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] tgt_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] r_o
);

    always_comb begin
        s_o = '0;
        r_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s_o[i] = (excite_bit(tgt_i[i], q_i[i]) == SET);
            r_o[i] = (excite_bit(tgt_i[i], q_i[i]) == CLR);
        end
    end

endmodule

// File: rtl/sr_bank_loader.sv
// Loads a target word into an SR flip-flop bank, verifies via q feedback, retries on mismatch.
//   state | meaning
//   IDLE  | ready for a target, S=R=0
//   DRIVE | registered S/R pulse applied for one cycle
//   CHECK | S=R=0, compare bank against target
//   DONE  | one-cycle completion with err/tries
module sr_bank_loader
    import sr_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RETRIES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tgt_valid,
    input  logic [WIDTH-1:0]                tgt_data,
    output logic                            tgt_ready,
    input  logic [WIDTH-1:0]                q_fb,
    output logic [WIDTH-1:0]                S,
    output logic [WIDTH-1:0]                R,
    output logic                            busy,
    output logic                            done_valid,
    output logic                            err,
    output logic [$clog2(RETRIES+2)-1:0]    tries
);

    localparam int TW = $clog2(RETRIES + 2);
    localparam logic [TW-1:0] MAX_RETRY = TW'(RETRIES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [TW-1:0]    att_q, att_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] exc_s;
    logic [WIDTH-1:0] exc_r;

    // On acceptance tgt_q is not yet loaded, so excite from the incoming word.
    assign exc_tgt = (state_q == IDLE) ? tgt_data : tgt_q;

    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .tgt_i (exc_tgt),
        .q_i   (q_fb),
        .s_o   (exc_s),
        .r_o   (exc_r)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        s_d     = '0;
        r_d     = '0;
        att_d   = att_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    att_d   = '0;
                    err_d   = 1'b0;
                    s_d     = exc_s;
                    r_d     = exc_r;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                att_d   = att_q + 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_q) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (att_q <= MAX_RETRY) begin
                    // att_q counts attempts, so retries used is att_q-1
                    s_d     = exc_s;
                    r_d     = exc_r;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            att_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            att_q   <= att_d;
            err_q   <= err_d;
        end
    end

    assign S          = s_q;
    assign R          = r_q;
    assign tgt_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done_valid = (state_q == DONE);
    assign err        = err_q;
    assign tries      = att_q;

endmodule

// File: tb/tb_sr_bank_loader.sv
// Directed bench for sr_bank_loader with a behavioural SR bank and optional stuck-at-0 bits.
module tb_sr_bank_loader;

    localparam int WIDTH   = 8;
    localparam int RETRIES = 2;
    localparam int TW      = $clog2(RETRIES + 2);

    logic             clk = 1'b0;
    logic             rst;
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done_valid;
    logic             err;
    logic [TW-1:0]    tries;

    logic [WIDTH-1:0] bank;
    logic             bank_ld;
    logic [WIDTH-1:0] bank_val;
    logic [WIDTH-1:0] stuck0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sr_bank_loader #(.WIDTH(WIDTH), .RETRIES(RETRIES)) dut (
        .clk        (clk),
        .rst        (rst),
        .tgt_valid  (tgt_valid),
        .tgt_data   (tgt_data),
        .tgt_ready  (tgt_ready),
        .q_fb       (q_fb),
        .S          (S),
        .R          (R),
        .busy       (busy),
        .done_valid (done_valid),
        .err        (err),
        .tries      (tries)
    );

    // Behavioural SR bank: set wins only when R is low; S=R=1 is flagged separately.
    always @(posedge clk) begin
        if (bank_ld) begin
            bank <= bank_val;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (S[i] && !R[i])      bank[i] <= 1'b1;
                else if (R[i] && !S[i]) bank[i] <= 1'b0;
            end
        end
    end
    assign q_fb = bank & ~stuck0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bank_ld !== 1'bx) chk("s_and_r_excl", 32'(S & R), 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input logic [WIDTH-1:0] v);
        bank_ld  = 1'b1;
        bank_val = v;
        tick();
        bank_ld  = 1'b0;
    endtask

    // Offer one target, follow it to done_valid, check pulses, latency and result.
    task automatic run(input string tag, input logic [WIDTH-1:0] tgt,
                       input logic [WIDTH-1:0] exp_s, input logic [WIDTH-1:0] exp_r,
                       input int exp_drv, input int exp_lat, input logic exp_err,
                       input int exp_tries, input logic [WIDTH-1:0] exp_bank);
        int  cyc;
        int  drv;
        bit  seen;
        chk({tag, "_ready"}, 32'(tgt_ready), 32'h1);
        tgt_valid = 1'b1;
        tgt_data  = tgt;
        tick();
        tgt_valid = 1'b0;
        drv  = 0;
        seen = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if ((S | R) != '0) begin
                drv++;
                chk({tag, "_S"}, 32'(S), 32'(exp_s));
                chk({tag, "_R"}, 32'(R), 32'(exp_r));
            end
            if (done_valid) begin
                seen = 1;
                chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
                chk({tag, "_err"}, 32'(err), 32'(exp_err));
                chk({tag, "_tries"}, 32'(tries), 32'(exp_tries));
                break;
            end
            chk({tag, "_busy"}, 32'(busy), 32'h1);
            chk({tag, "_notready"}, 32'(tgt_ready), 32'h0);
            tick();
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'h1);
        chk({tag, "_drives"}, 32'(drv), 32'(exp_drv));
        tick();
        chk({tag, "_bank"}, 32'(q_fb), 32'(exp_bank));
        chk({tag, "_idle_ready"}, 32'(tgt_ready), 32'h1);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        bank_ld   = 1'b0;
        bank_val  = '0;
        stuck0    = '0;
        tick();
        tick();
        chk("rst_S", 32'(S), 32'h0);
        chk("rst_R", 32'(R), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_tries", 32'(tries), 32'h0);
        chk("rst_ready", 32'(tgt_ready), 32'h1);
        rst = 1'b0;
        tick();

        set_bank(8'h00);
        run("a5", 8'hA5, 8'hA5, 8'h00, 1, 3, 1'b0, 1, 8'hA5);

        set_bank(8'hF0);
        run("0f", 8'h0F, 8'h0F, 8'hF0, 1, 3, 1'b0, 1, 8'h0F);

        set_bank(8'h3C);
        run("same", 8'h3C, 8'h00, 8'h00, 0, 3, 1'b0, 1, 8'h3C);

        set_bank(8'h00);
        stuck0 = 8'h01;
        run("stuck", 8'h01, 8'h01, 8'h00, 3, 7, 1'b1, 3, 8'h00);
        stuck0 = 8'h00;

        // Reset while in CHECK: no completion must escape.
        set_bank(8'h00);
        tgt_valid = 1'b1;
        tgt_data  = 8'hFF;
        tick();
        tgt_valid = 1'b0;
        tick();
        chk("rsti_inchk_S", 32'(S), 32'h0);
        chk("rsti_inchk_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        chk("rsti_S", 32'(S), 32'h0);
        chk("rsti_R", 32'(R), 32'h0);
        chk("rsti_busy", 32'(busy), 32'h0);
        chk("rsti_done", 32'(done_valid), 32'h0);
        rst = 1'b0;
        tick();
        chk("rsti_ready", 32'(tgt_ready), 32'h1);
        chk("rsti_done2", 32'(done_valid), 32'h0);
        tick();
        chk("rsti_done3", 32'(done_valid), 32'h0);

        // Back-to-back offers with tgt_valid held high.
        set_bank(8'h00);
        tgt_valid = 1'b1;
        tgt_data  = 8'h11;
        tick();
        tgt_data  = 8'h22;
        for (cyc = 1; cyc <= 3; cyc++) begin
            chk("b2b_ready_low", 32'(tgt_ready), 32'h0);
            chk("b2b_done1", 32'(done_valid), 32'(cyc == 3));
            if (cyc == 3) chk("b2b_err1", 32'(err), 32'h0);
            tick();
        end
        chk("b2b_bank1", 32'(q_fb), 32'h11);
        chk("b2b_ready_idle", 32'(tgt_ready), 32'h1);
        tick();
        tgt_valid = 1'b0;
        chk("b2b_S2", 32'(S), 32'h22);
        chk("b2b_R2", 32'(R), 32'h11);
        tick();
        tick();
        chk("b2b_done2", 32'(done_valid), 32'h1);
        chk("b2b_err2", 32'(err), 32'h0);
        chk("b2b_tries2", 32'(tries), 32'h1);
        tick();
        chk("b2b_bank2", 32'(q_fb), 32'h22);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sr_bank_loader.md
# sr_bank_loader

Drives a bank of WIDTH SR flip-flops so that their outputs reach a requested target word, using the SR excitation table (set, reset or hold, per bit). It never issues the illegal S=R=1 combination. It reads the bank's q outputs back to confirm the load, retries on mismatch, and reports completion with a pass/fail flag. It sits between a control source (valid/ready target stream) and the SR flip-flop register bank.

## Interface
- WIDTH, 8, number of SR flip-flops driven (≥1)
- RETRIES, 2, extra drive attempts after a failed check (≥0)
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- tgt_valid  in  1  target word offered
- tgt_data  in  WIDTH  requested bank value
- tgt_ready  out  1  loader can accept a target (high only in IDLE)
- q_fb  in  WIDTH  q outputs of the SR flip-flop bank
- S  out  WIDTH  set inputs to the bank, registered
- R  out  WIDTH  reset inputs to the bank, registered
- busy  out  1  high in DRIVE, CHECK and DONE
- done_valid  out  1  one-cycle completion pulse
- err  out  1  valid with done_valid; 1 means the final check failed
- tries  out  clog2(RETRIES+2)  drive attempts used, valid with done_valid

## Operation
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - tgt_ready=1, S=R=0.
  - On tgt_valid&&tgt_ready: latch tgt_data into tgt_q, clear the attempt counter, and go to DRIVE.
  - On the same edge, load S and R from the per-bit excitation:
    - S[i] = tgt_q[i] & ~q_fb[i]
    - R[i] = ~tgt_q[i] & q_fb[i]
    - Bits already equal to the target get S=R=0 (hold).
- DRIVE: lasts exactly 1 cycle with S/R held. Then S=R=0 and go to CHECK; the attempt counter increments.
- CHECK: S=R=0. Compare q_fb with tgt_q.
  - Match: go to DONE with err=0.
  - Mismatch and retries used < RETRIES: go to DRIVE, reloading S/R from the current q_fb.
  - Mismatch and retries exhausted: go to DONE with err=1.
- DONE: done_valid=1, err and tries stable for this one cycle, then go to IDLE.
- Invariant: (S & R) == 0 on every cycle, including reset and retries.
- tgt_valid outside IDLE is ignored. The offer is not consumed and must be held by the source until tgt_ready.
- A target equal to the current bank value still runs DRIVE (all holds) and CHECK, and completes with err=0, tries=1.
- RETRIES=0: a single attempt only.

## Timing
- Reset values: state=IDLE, S=0, R=0, busy=0, done_valid=0, err=0, tries=0, tgt_ready=1 (decoded from IDLE).
- rst asserted in any state: on the next edge, return to IDLE with all of the above values. S/R drop to 0 on that same edge and no partial completion is reported.
- Acceptance edge = edge 0. S/R are active during cycle 1; the bank captures at edge 1. CHECK occupies cycle 2. done_valid is high in cycle 3.
- Latency from acceptance to done_valid is 3 cycles for the first attempt, plus 2 per retry. Worst case is 3+2·RETRIES.
- Throughput: the next target can be accepted at the edge ending the cycle after DONE (IDLE has at least 1 cycle).
- q_fb is sampled only at the end of CHECK and at the edges entering DRIVE. It is assumed to settle within one cycle of an S/R pulse.

## Structure
- Shared package sr_pkg:
  - state enum (IDLE, DRIVE, CHECK, DONE)
  - encodings of the excitation actions HOLD=2'b00, CLR=2'b01, SET=2'b10, with 2'b11 defined as ILLEGAL for assertions
- Sub-module sr_excite: combinational, per word. Maps (tgt, q) to {S,R} from the excitation table and guarantees S&R==0. The top level registers its outputs.
- Top level: FSM, tgt_q register, attempt counter, output registers.

## Test plan
- Reset, then bank=8'h00, target 8'hA5:
  - S=8'hA5, R=8'h00 for exactly one cycle.
  - done_valid 3 cycles after acceptance, err=0, tries=1, bank reads 8'hA5.
- Bank=8'hF0, target 8'h0F: S=8'h0F, R=8'hF0, err=0. Assert (S&R)==0 on every cycle of every test.
- Bank=8'h3C, target 8'h3C: S=R=0 throughout, done_valid at +3, err=0, tries=1.
- Bench forces bit 0 of the bank stuck-at-0, target 8'h01, RETRIES=2:
  - three DRIVE pulses with S=8'h01.
  - done_valid at +7, err=1, tries=3.
- Accept target 8'hFF, then assert rst during CHECK:
  - next edge: IDLE, S=R=0, busy=0, no done_valid.
  - tgt_ready=1 after the edge on which rst is sampled low.
- tgt_valid held high with 8'h11 then 8'h22 back-to-back:
  - 8'h22 is not accepted until IDLE.
  - tgt_ready low from acceptance through DONE.
  - both loads complete, with err=0 each.
